seq_array_mult: RTL and testbench

Sequential, parametrised shift-add multiplier: the next generation of the team's 4x4 combinational array multiplier. It handles WIDTH-bit operands in unsigned or two's-complement mode and computes one partial-product row per clock instead of a full adder array. Valid/ready handshakes on input and output let it sit between a register-file/operand source and a result consumer that may stall. It trades latency for area, which is the main cost driver on a small-tile die.

---
 rtl/seq_array_mult.sv | 166 ++++++++++++++++
 tb/tb_seq_array_mult.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_array_mult.sv
// Sequential shift-add multiplier: one partial-product row per clock, unsigned or
// two's-complement operands, valid/ready handshakes on both sides.
module seq_array_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 tc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Magnitude of a WIDTH-bit operand; -2^(WIDTH-1) maps onto itself as unsigned.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && x[WIDTH-1]) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mag_m_q, mag_m_d;
    logic [WIDTH-1:0] mag_q_q, mag_q_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    p_q, p_d;

    logic [WIDTH-1:0] m_mag_s, q_mag_s;
    logic             zero_s, last_s;
    logic [PW-1:0]    addend_s, acc_sum_s;

    assign m_mag_s   = mag_of(m, tc);
    assign q_mag_s   = mag_of(q, tc);
    assign zero_s    = (m_mag_s == {WIDTH{1'b0}}) || (q_mag_s == {WIDTH{1'b0}});
    assign last_s    = (cnt_q == CW'(WIDTH - 1));
    assign addend_s  = mag_q_q[cnt_q] ? ({{WIDTH{1'b0}}, mag_m_q} << cnt_q) : {PW{1'b0}};
    assign acc_sum_s = acc_q + addend_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_m_q <= {WIDTH{1'b0}};
            mag_q_q <= {WIDTH{1'b0}};
            neg_q   <= 1'b0;
            acc_q   <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            p_q     <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            mag_m_q <= mag_m_d;
            mag_q_q <= mag_q_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = zero_s ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, one shift-add row per RUN cycle
    always_comb begin
        mag_m_d = mag_m_q;
        mag_q_d = mag_q_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mag_m_d = m_mag_s;
                    mag_q_d = q_mag_s;
                    neg_d   = tc & (m[WIDTH-1] ^ q[WIDTH-1]);
                    acc_d   = {PW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    if (zero_s) begin
                        p_d = {PW{1'b0}};
                    end else begin
                        p_d = p_q;
                    end
                end else begin
                    p_d = p_q;
                end
            end
            S_RUN: begin
                acc_d = acc_sum_s;
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
                    p_d = neg_q ? -acc_sum_s : acc_sum_s;
                end else begin
                    p_d = p_q;
                end
            end
            S_DONE: begin
                p_d = p_q;
            end
            default: begin
                p_d = p_q;
            end
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    assign p = p_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// Bench for seq_array_mult: directed WIDTH=4 cases and a random WIDTH=8 sweep,
// checked against an arithmetic reference product.
module tb_seq_array_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv4 = 1'b0, or4 = 1'b0, tc4 = 1'b0;
    logic [3:0] m4 = 4'd0, q4 = 4'd0;
    logic       ir4, ov4, busy4;
    logic [7:0] p4;

    logic       iv8 = 1'b0, or8 = 1'b0, tc8 = 1'b0;
    logic [7:0] m8 = 8'd0, q8 = 8'd0;
    logic       ir8, ov8, busy8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;

    seq_array_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .m(m4), .q(q4), .tc(tc4),
        .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
    );

    seq_array_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .m(m8), .q(q8), .tc(tc8),
        .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic t);
        longint sa, sb, mask_w, mask_p;
        mask_w = (longint'(1) << w) - 1;
        mask_p = (longint'(1) << (2 * w)) - 1;
        sa = longint'(a) & mask_w;
        sb = longint'(b) & mask_w;
        if (t && sa[w-1]) sa = sa - (longint'(1) << w);
        if (t && sb[w-1]) sb = sb - (longint'(1) << w);
        return 32'((sa * sb) & mask_p);
    endfunction

    function automatic logic f_ir(input int w);   return (w == 4) ? ir4 : ir8;     endfunction
    function automatic logic f_ov(input int w);   return (w == 4) ? ov4 : ov8;     endfunction
    function automatic logic f_busy(input int w); return (w == 4) ? busy4 : busy8; endfunction
    function automatic logic [31:0] f_p(input int w);
        return (w == 4) ? {24'd0, p4} : {16'd0, p8};
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic t);
        if (w == 4) begin
            iv4 = v; m4 = a[3:0]; q4 = b[3:0]; tc4 = t;
        end else begin
            iv8 = v; m8 = a[7:0]; q8 = b[7:0]; tc8 = t;
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 4) or4 = r;
        else        or8 = r;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction, starting and ending on a negedge with the DUT idle.
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic t,
                         input int stall, input logic [31:0] expv, input bit poke);
        int  k;
        int  bsy;
        bit  zero;
        logic [15:0] mask_w;
        mask_w = 16'((32'd1 << w) - 32'd1);
        zero = ((a & mask_w) == 16'd0) || ((b & mask_w) == 16'd0);
        check_eq("in_ready_idle", 32'(f_ir(w)), 32'd1);
        set_ready(w, (stall == 0));
        drive(w, 1'b1, a, b, t);
        step();
        drive(w, 1'b0, 16'd0, 16'd0, 1'b0);
        k = 0;
        bsy = 0;
        while (!f_ov(w) && k < 40) begin
            if (f_busy(w)) bsy++;
            check_eq("in_ready_low", 32'(f_ir(w)), 32'd0);
            step();
            k++;
        end
        check_eq("latency", 32'(k), zero ? 32'd0 : 32'(w));
        check_eq("busy_cycles", 32'(bsy), zero ? 32'd0 : 32'(w));
        check_eq("out_valid", 32'(f_ov(w)), 32'd1);
        check_eq("product", f_p(w), expv);
        for (int s = 0; s < stall; s++) begin
            if (poke) drive(w, 1'b1, ~a, ~b, ~t);
            step();
            check_eq("hold_valid", 32'(f_ov(w)), 32'd1);
            check_eq("hold_p", f_p(w), expv);
            if (poke) check_eq("no_accept_done", 32'(f_ir(w)), 32'd0);
        end
        drive(w, 1'b0, 16'd0, 16'd0, 1'b0);
        set_ready(w, 1'b1);
        step();
        set_ready(w, 1'b0);
        check_eq("valid_drop", 32'(f_ov(w)), 32'd0);
        check_eq("ready_back", 32'(f_ir(w)), 32'd1);
    endtask

    initial begin
        logic [15:0] a, b;
        logic        t;
        @(negedge clk);
        step();
        check_eq("rst_in_ready", 32'(ir4), 32'd1);
        check_eq("rst_out_valid", 32'(ov4), 32'd0);
        check_eq("rst_busy", 32'(busy4), 32'd0);
        check_eq("rst_p", {24'd0, p4}, 32'd0);
        check_eq("rst_p8", {16'd0, p8}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(4, 16'hF, 16'hF, 1'b0, 0, 32'hE1, 1'b0);
        do_op(4, 16'h8, 16'h8, 1'b1, 1, 32'h40, 1'b0);
        do_op(4, 16'h8, 16'h7, 1'b1, 0, 32'hC8, 1'b0);
        do_op(4, 16'h3, 16'hD, 1'b1, 2, 32'hF7, 1'b0);
        do_op(4, 16'h0, 16'h9, 1'b0, 0, 32'h00, 1'b0);
        do_op(4, 16'h6, 16'h7, 1'b0, 5, 32'h2A, 1'b1);
        do_op(4, 16'h2, 16'h3, 1'b0, 0, 32'h06, 1'b0);

        // Reset two cycles into RUN must discard the operation silently.
        drive(4, 1'b1, 16'h7, 16'h6, 1'b0);
        or4 = 1'b1;
        step();
        drive(4, 1'b0, 16'd0, 16'd0, 1'b0);
        check_eq("run_busy", 32'(busy4), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_in_ready", 32'(ir4), 32'd1);
        check_eq("mid_rst_out_valid", 32'(ov4), 32'd0);
        check_eq("mid_rst_p", {24'd0, p4}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("no_stale", 32'(ov4), 32'd0);
        end
        or4 = 1'b0;
        do_op(4, 16'h5, 16'h5, 1'b0, 0, 32'h19, 1'b0);

        do_op(8, 16'h80, 16'h80, 1'b1, 1, 32'h4000, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom_range(0, 255));
            b = 16'($urandom_range(0, 255));
            case ($urandom_range(0, 15))
                0:       a = 16'd0;
                1:       b = 16'd0;
                2:       a = 16'h80;
                3:       b = 16'hFF;
                default: a = a;
            endcase
            t = 1'($urandom_range(0, 1));
            do_op(8, a, b, t, int'($urandom_range(0, 3)), ref_mul(8, a, b, t), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
